key_step_ctrl: RTL and testbench
================================

Name: key_step_ctrl

Overview:
- Multi-channel push-button controller that turns raw asynchronous key inputs into clean single-cycle step pulses for the lab top level.
- Per key: 2-flop synchronizer, then a debounce/auto-repeat FSM.
- Press events from all keys are merged into one encoded event stream through a lowest-index-first pending queue.
- Feeds the step/advance inputs of downstream CPU/debug logic, replacing ad-hoc edge detectors.

Parameters:
- N_KEYS, 4, number of key channels (1..16).
- DB_CYCLES, 4, cycles a synchronized level must stay stable to be accepted (board build overrides to 1_000_000).
- HOLD_CYCLES, 10, cycles in PRESSED before the first auto-repeat.
- RPT_CYCLES, 3, period between auto-repeat pulses.
- CNT_W, $clog2(max of the three cycle params)+1, internal counter width.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- key_in  in  N_KEYS  raw asynchronous key levels, 1 = pressed
- rpt_en  in  1  1 = auto-repeat enabled (sampled every cycle)
- key_level  out  N_KEYS  debounced level per key
- key_pulse  out  N_KEYS  one-cycle pulse per accepted press or repeat
- evt_valid  out  1  one-cycle strobe, one event served
- evt_code  out  $clog2(N_KEYS) (min 1)  index of the served key

Behaviour:
- Reset: clk single domain; rstn asynchronous active-low. On reset, all sync flops, counters, and pending bits are 0, every FSM is in IDLE, and all outputs are 0. Reset asserted mid-operation aborts everything; no pulse or event is emitted afterwards.
- Synchronizer: s[i] = second flop of key_in[i]. s is valid 2 edges after key_in changes.
- Per-key FSM, counter cnt:
  - IDLE: s=1 -> DB_PRESS, cnt=0.
  - DB_PRESS: s=0 -> IDLE. s=1 and cnt==DB_CYCLES-1 -> PRESSED, cnt=0, pulse. Otherwise cnt++.
  - PRESSED: s=0 -> DB_REL, cnt=0. rpt_en=1 and cnt==HOLD_CYCLES-1 -> REPEAT, cnt=0, pulse. Otherwise cnt++, saturating at HOLD_CYCLES-1 when rpt_en=0.
  - REPEAT: s=0 -> DB_REL, cnt=0. rpt_en=0 -> PRESSED, cnt=0. cnt==RPT_CYCLES-1 -> cnt=0, pulse. Otherwise cnt++.
  - DB_REL: s=1 -> PRESSED, cnt=0 (hold timer restarts, no pulse). s=0 and cnt==DB_CYCLES-1 -> IDLE. Otherwise cnt++.
- key_level[i] = 1 in PRESSED, REPEAT, DB_REL. Registered; changes on the same edge as the state.
- key_pulse[i]: registered, high exactly during the first cycle after the transition edge that generates the pulse.
- Latency: key_in rising before edge E1 -> key_pulse high in cycle after edge E1+DB_CYCLES+2.
- Event queue:
  - pend[i] is set on the same edge key_pulse[i] is set.
  - Each cycle, if pend != 0, the lowest set index j is served on the next edge: evt_valid=1, evt_code=j, pend[j] cleared.
  - A new pulse for a key that is already pending merges (one event).
  - Set and clear of the same bit on the same edge: set wins.
  - Max one event per cycle.
  - evt_code holds its last value while evt_valid=0.
- Boundary: DB_CYCLES=1 must work (one stable cycle accepts). Counters never wrap; all compares are exact equality at terminal count.

Decomposition:
- Package key_step_pkg: FSM state enum (IDLE, DB_PRESS, PRESSED, REPEAT, DB_REL) and a clog2-safe width function.
- Sub-module key_chan: synchronizer + FSM + counter, generates key_level/key_pulse. Instantiated N_KEYS times via generate.
- Top: pending vector and priority encoder.

Test Plan:
- Clean press, key0 high before E1 for 40 cycles, rpt_en=0, defaults -> key_pulse[0] after E7 only; evt_valid with code 0 after E8; key_level[0] rises at E7 and falls 4+3 edges after release.
- Glitch: key1 high for 3 cycles -> no key_pulse, no evt_valid, key_level[1] stays 0.
- Auto-repeat: key0 held 30 cycles, rpt_en=1 -> pulses after E7, E17, E20, E23, E26, E29 (and further multiples of 3 until release is seen).
- Simultaneous: key0 and key2 rise on the same cycle -> both key_pulse in the same cycle; evt code 0, then code 2 on the next cycle; pend empty after.
- Release bounce: during hold, key0 drops for 2 cycles -> DB_REL then back to PRESSED, no extra pulse, hold timer restarted (repeat 10 cycles after return).
- Reset mid-debounce: rstn low for 1 cycle while key3 is in DB_PRESS -> all outputs 0; with key3 still high, a pulse appears DB_CYCLES+3 edges after rstn release.

Source files
------------

// File: rtl/key_step_pkg.sv
// Shared types and elaboration-time helpers for the key step controller.
// Contents:
//   key_state_e  - per-key debounce / auto-repeat state
//   clog2_safe   - ceil(log2(n)) with a minimum of 1 (for index widths)
//   cnt_width    - counter width wide enough for the largest cycle count
package key_step_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DB_PRESS = 3'd1,
        PRESSED  = 3'd2,
        REPEAT   = 3'd3,
        DB_REL   = 3'd4
    } key_state_e;

    function automatic int clog2_safe(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/key_step_ctrl_if.sv
// Bundle between the key step controller and its user.
// Signals:
//   key_in    raw asynchronous key levels, 1 = pressed
//   rpt_en    auto-repeat enable, sampled every cycle
//   key_level debounced level per key
//   key_pulse one-cycle pulse per accepted press or repeat
//   evt_valid one-cycle strobe, one event served
//   evt_code  index of the served key (holds while evt_valid = 0)
// Modports: master drives key_in/rpt_en, slave (the controller) drives the rest.
interface key_step_ctrl_if import key_step_pkg::*; #(
    parameter int N_KEYS = 4
);
    localparam int CODE_W = clog2_safe(N_KEYS);

    logic [N_KEYS-1:0] key_in;
    logic              rpt_en;
    logic [N_KEYS-1:0] key_level;
    logic [N_KEYS-1:0] key_pulse;
    logic              evt_valid;
    logic [CODE_W-1:0] evt_code;

    modport master (
        output key_in, rpt_en,
        input  key_level, key_pulse, evt_valid, evt_code
    );

    modport slave (
        input  key_in, rpt_en,
        output key_level, key_pulse, evt_valid, evt_code
    );
endinterface

// File: rtl/key_chan.sv
// One key channel: 2-flop synchronizer followed by a debounce / auto-repeat
// FSM with a single shared cycle counter.
// Ports:
//   clk, rstn  clock, asynchronous active-low reset
//   key_raw    raw asynchronous key level
//   rpt_en     auto-repeat enable
//   key_level  registered debounced level
//   key_pulse  registered one-cycle press / repeat pulse
//   pulse_set  combinational: key_pulse will be set on the coming edge
//              (lets the event queue capture on the same edge)
module key_chan import key_step_pkg::*; #(
    parameter int DB_CYCLES   = 4,
    parameter int HOLD_CYCLES = 10,
    parameter int RPT_CYCLES  = 3,
    parameter int CNT_W       = cnt_width(DB_CYCLES, HOLD_CYCLES, RPT_CYCLES)
) (
    input  logic clk,
    input  logic rstn,
    input  logic key_raw,
    input  logic rpt_en,
    output logic key_level,
    output logic key_pulse,
    output logic pulse_set
);
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(RPT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic             sync1_r;
    logic             sync2_r;
    key_state_e       state_r;
    key_state_e       state_nx_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nx_s;
    logic             level_r;
    logic             level_nx_s;
    logic             pulse_r;
    logic             pulse_nx_s;

    // Two-flop synchronizer for the raw key level.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= key_raw;
            sync2_r <= sync1_r;
        end
    end

    // Next-state, counter and pulse decode for the debounce / repeat FSM.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        pulse_nx_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (sync2_r) begin
                    state_nx_s = DB_PRESS;
                    cnt_nx_s   = CNT_ZERO;
                end else begin
                    cnt_nx_s   = CNT_ZERO;
                end
            end
            DB_PRESS: begin
                if (!sync2_r) begin
                    state_nx_s = IDLE;
                    cnt_nx_s   = CNT_ZERO;
                end else if (cnt_r == DB_LAST) begin
                    state_nx_s = PRESSED;
                    cnt_nx_s   = CNT_ZERO;
                    pulse_nx_s = 1'b1;
                end else begin
                    cnt_nx_s   = cnt_r + CNT_ONE;
                end
            end
            PRESSED: begin
                if (!sync2_r) begin
                    state_nx_s = DB_REL;
                    cnt_nx_s   = CNT_ZERO;
                end else if (rpt_en && (cnt_r == HOLD_LAST)) begin
                    state_nx_s = REPEAT;
                    cnt_nx_s   = CNT_ZERO;
                    pulse_nx_s = 1'b1;
                end else if (cnt_r != HOLD_LAST) begin
                    cnt_nx_s   = cnt_r + CNT_ONE;
                end else begin
                    // Hold timer parks at its terminal value until repeat is enabled.
                    cnt_nx_s   = cnt_r;
                end
            end
            REPEAT: begin
                if (!sync2_r) begin
                    state_nx_s = DB_REL;
                    cnt_nx_s   = CNT_ZERO;
                end else if (!rpt_en) begin
                    state_nx_s = PRESSED;
                    cnt_nx_s   = CNT_ZERO;
                end else if (cnt_r == RPT_LAST) begin
                    cnt_nx_s   = CNT_ZERO;
                    pulse_nx_s = 1'b1;
                end else begin
                    cnt_nx_s   = cnt_r + CNT_ONE;
                end
            end
            DB_REL: begin
                if (sync2_r) begin
                    // Release bounce: back to held, hold timer restarts, no pulse.
                    state_nx_s = PRESSED;
                    cnt_nx_s   = CNT_ZERO;
                end else if (cnt_r == DB_LAST) begin
                    state_nx_s = IDLE;
                    cnt_nx_s   = CNT_ZERO;
                end else begin
                    cnt_nx_s   = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nx_s = IDLE;
                cnt_nx_s   = CNT_ZERO;
            end
        endcase
        level_nx_s = (state_nx_s == PRESSED) || (state_nx_s == REPEAT) ||
                     (state_nx_s == DB_REL);
    end

    // FSM state, counter and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
            level_r <= 1'b0;
            pulse_r <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
            level_r <= level_nx_s;
            pulse_r <= pulse_nx_s;
        end
    end

    assign key_level = level_r;
    assign key_pulse = pulse_r;
    assign pulse_set = pulse_nx_s;

endmodule

// File: rtl/key_step_ctrl.sv
// Multi-channel push-button controller: N_KEYS debounce/repeat channels whose
// press events are merged into one encoded stream, lowest index first.
// Ports:
//   clk, rstn  clock, asynchronous active-low reset
//   bus        key_step_ctrl_if slave: key_in, rpt_en in;
//              key_level, key_pulse, evt_valid, evt_code out
module key_step_ctrl import key_step_pkg::*; #(
    parameter int N_KEYS      = 4,
    parameter int DB_CYCLES   = 4,
    parameter int HOLD_CYCLES = 10,
    parameter int RPT_CYCLES  = 3,
    parameter int CNT_W       = cnt_width(DB_CYCLES, HOLD_CYCLES, RPT_CYCLES)
) (
    input  logic            clk,
    input  logic            rstn,
    key_step_ctrl_if.slave  bus
);
    localparam int CODE_W = clog2_safe(N_KEYS);

    logic [N_KEYS-1:0] level_s;
    logic [N_KEYS-1:0] pulse_s;
    logic [N_KEYS-1:0] set_s;
    logic [N_KEYS-1:0] pend_r;
    logic [N_KEYS-1:0] pend_nx_s;
    logic [N_KEYS-1:0] grant_s;
    logic [CODE_W-1:0] grant_code_s;
    logic              evt_valid_r;
    logic [CODE_W-1:0] evt_code_r;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
        key_chan #(
            .DB_CYCLES   (DB_CYCLES),
            .HOLD_CYCLES (HOLD_CYCLES),
            .RPT_CYCLES  (RPT_CYCLES),
            .CNT_W       (CNT_W)
        ) u_chan (
            .clk       (clk),
            .rstn      (rstn),
            .key_raw   (bus.key_in[i]),
            .rpt_en    (bus.rpt_en),
            .key_level (level_s[i]),
            .key_pulse (pulse_s[i]),
            .pulse_set (set_s[i])
        );
    end

    // Lowest pending bit wins; a fresh pulse on the granted bit re-sets it.
    always_comb begin
        grant_s      = pend_r & (~pend_r + N_KEYS'(1));
        grant_code_s = {CODE_W{1'b0}};
        for (int i = 0; i < N_KEYS; i++) begin
            // grant_s is one-hot (or zero), so OR-ing the indices encodes it.
            grant_code_s = grant_code_s | (grant_s[i] ? CODE_W'(i) : {CODE_W{1'b0}});
        end
        pend_nx_s = (pend_r & ~grant_s) | set_s;
    end

    // Pending vector and the served-event outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pend_r      <= {N_KEYS{1'b0}};
            evt_valid_r <= 1'b0;
            evt_code_r  <= {CODE_W{1'b0}};
        end else begin
            pend_r      <= pend_nx_s;
            evt_valid_r <= |pend_r;
            if (|pend_r) begin
                evt_code_r <= grant_code_s;
            end else begin
                evt_code_r <= evt_code_r;
            end
        end
    end

    assign bus.key_level = level_s;
    assign bus.key_pulse = pulse_s;
    assign bus.evt_valid = evt_valid_r;
    assign bus.evt_code  = evt_code_r;

endmodule

// File: tb/tb_key_step_ctrl.sv
// Self-checking bench for key_step_ctrl: directed scenarios plus random
// stimulus, checked against a behavioural model built from the key rules
// (disagreement streaks, hold age, pending set), not from the FSM encoding.
module tb_key_step_ctrl;
    localparam int N    = 4;
    localparam int DB   = 4;
    localparam int HOLD = 10;
    localparam int RPT  = 3;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    key_step_ctrl_if #(.N_KEYS(N)) bus ();
    key_step_ctrl_if #(.N_KEYS(N)) bus1 ();

    key_step_ctrl #(.N_KEYS(N), .DB_CYCLES(DB), .HOLD_CYCLES(HOLD), .RPT_CYCLES(RPT))
        dut (.clk(clk), .rstn(rstn), .bus(bus));

    key_step_ctrl #(.N_KEYS(N), .DB_CYCLES(1), .HOLD_CYCLES(HOLD), .RPT_CYCLES(RPT))
        dut_db1 (.clk(clk), .rstn(rstn), .bus(bus1));

    int n_vec = 0;
    int n_bad = 0;

    // ---------------- behavioural model (main DUT) ----------------
    logic [N-1:0] m_q1, m_q2, m_lvl, m_rep, m_pulse, m_pend;
    int           m_streak [N];   // consecutive samples disagreeing with m_lvl
    int           m_age    [N];   // samples since hold / repeat timer restart
    logic         m_valid;
    logic [1:0]   m_code;

    function automatic void model_reset();
        m_q1 = '0; m_q2 = '0; m_lvl = '0; m_rep = '0; m_pulse = '0; m_pend = '0;
        m_valid = 1'b0; m_code = 2'd0;
        for (int i = 0; i < N; i++) begin
            m_streak[i] = 0;
            m_age[i]    = 0;
        end
    endfunction

    function automatic void model_edge();
        logic [N-1:0] s;
        logic [N-1:0] np;
        int low;
        s  = m_q2;
        np = '0;
        low = -1;
        for (int j = 0; j < N; j++) if (low < 0 && m_pend[j]) low = j;
        m_valid = (low >= 0);
        if (low >= 0) begin
            m_code      = 2'(low);
            m_pend[low] = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            if (!m_lvl[i]) begin
                if (s[i]) begin
                    m_streak[i]++;
                    if (m_streak[i] == DB + 1) begin
                        m_lvl[i] = 1'b1; m_streak[i] = 0; m_age[i] = 0; m_rep[i] = 1'b0;
                        np[i] = 1'b1;
                    end
                end else m_streak[i] = 0;
            end else if (!s[i]) begin
                m_streak[i]++;
                if (m_streak[i] == DB + 1) begin
                    m_lvl[i] = 1'b0; m_streak[i] = 0;
                end
            end else if (m_streak[i] != 0) begin
                m_streak[i] = 0; m_age[i] = 0; m_rep[i] = 1'b0;
            end else if (!m_rep[i]) begin
                if (bus.rpt_en && m_age[i] == HOLD - 1) begin
                    m_rep[i] = 1'b1; m_age[i] = 0; np[i] = 1'b1;
                end else if (m_age[i] < HOLD - 1) m_age[i]++;
            end else begin
                if (!bus.rpt_en) begin
                    m_rep[i] = 1'b0; m_age[i] = 0;
                end else if (m_age[i] == RPT - 1) begin
                    m_age[i] = 0; np[i] = 1'b1;
                end else m_age[i]++;
            end
        end
        m_pend  = m_pend | np;
        m_pulse = np;
        m_q2    = m_q1;
        m_q1    = bus.key_in;
    endfunction

    // Advance one clock: model follows the active edge, sampling at the negedge.
    task automatic tick();
        @(posedge clk);
        if (!rstn) model_reset();
        else model_edge();
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        repeat (3) tick();
        n_vec++;
        if ({bus.key_level, bus.key_pulse, bus.evt_valid, bus.evt_code} !== 11'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h want 000", {bus.key_level, bus.key_pulse, bus.evt_valid, bus.evt_code});
        end
        n_vec++;
        if ({bus1.key_level, bus1.key_pulse, bus1.evt_valid, bus1.evt_code} !== 11'd0) begin
            n_bad++;
            $display("FAIL reset_outputs_db1: got %h want 000", {bus1.key_level, bus1.key_pulse, bus1.evt_valid, bus1.evt_code});
        end
        rstn = 1'b1;
    endtask

    task automatic test_db1();
        int p_at = -1, np0 = 0, np1 = 0, rise = -1, fall = -1, nevt = 0, evt_at = -1;
        bus1.key_in = 4'b0001;
        for (int t = 1; t <= 14; t++) begin
            if (t == 3) bus1.key_in = 4'b0010;
            if (t == 4) bus1.key_in = 4'b0000;
            tick();
            if (bus1.key_pulse[0]) begin np0++; p_at = t; end
            if (bus1.key_pulse[1] || bus1.key_level[1]) np1++;
            if (bus1.key_level[0] && rise < 0) rise = t;
            if (!bus1.key_level[0] && rise >= 0 && fall < 0) fall = t;
            if (bus1.evt_valid) begin nevt++; evt_at = t; end
        end
        n_vec++;
        if (np0 != 1 || p_at != 4) begin
            n_bad++; $display("FAIL db1_pulse: got count %0d at %0d want 1 at 4", np0, p_at);
        end
        n_vec++;
        if (rise != 4 || fall != 6) begin
            n_bad++; $display("FAIL db1_level: got rise %0d fall %0d want 4 6", rise, fall);
        end
        n_vec++;
        if (np1 != 0) begin
            n_bad++; $display("FAIL db1_glitch: got %0d activity cycles want 0", np1);
        end
        n_vec++;
        if (nevt != 1 || evt_at != 5 || bus1.evt_code !== 2'd0) begin
            n_bad++; $display("FAIL db1_event: got %0d events last at %0d code %0d want 1 at 5 code 0", nevt, evt_at, bus1.evt_code);
        end
    endtask

    task automatic test_clean_press();
        int p_at = -1, np = 0, evt_at = -1, rise = -1, fall = -1;
        logic [1:0] evt_c = 2'd3;
        bus.rpt_en = 1'b0;
        bus.key_in = 4'b0001;
        for (int t = 1; t <= 60; t++) begin
            if (t == 41) bus.key_in = 4'b0000;
            tick();
            n_vec++;
            if ({bus.key_level, bus.key_pulse, bus.evt_valid, bus.evt_code} !== {m_lvl, m_pulse, m_valid, m_code}) begin
                n_bad++; $display("FAIL clean_model t=%0d: got %h want %h", t, {bus.key_level, bus.key_pulse, bus.evt_valid, bus.evt_code}, {m_lvl, m_pulse, m_valid, m_code});
            end
            if (bus.key_pulse[0]) begin np++; p_at = t; end
            if (bus.evt_valid && evt_at < 0) begin evt_at = t; evt_c = bus.evt_code; end
            if (bus.key_level[0] && rise < 0) rise = t;
            if (!bus.key_level[0] && rise >= 0 && fall < 0) fall = t;
        end
        n_vec++;
        if (np != 1 || p_at != DB + 3) begin
            n_bad++; $display("FAIL clean_pulse: got count %0d at %0d want 1 at %0d", np, p_at, DB + 3);
        end
        n_vec++;
        if (evt_at != DB + 4 || evt_c !== 2'd0) begin
            n_bad++; $display("FAIL clean_event: got at %0d code %0d want at %0d code 0", evt_at, evt_c, DB + 4);
        end
        n_vec++;
        if (rise != DB + 3 || fall != 40 + DB + 3) begin
            n_bad++; $display("FAIL clean_level: got rise %0d fall %0d want %0d %0d", rise, fall, DB + 3, 40 + DB + 3);
        end
    endtask

    task automatic test_glitch();
        int act = 0;
        bus.key_in = 4'b0010;
        for (int t = 1; t <= 15; t++) begin
            if (t == 4) bus.key_in = 4'b0000;
            tick();
            n_vec++;
            if ({bus.key_level, bus.key_pulse, bus.evt_valid, bus.evt_code} !== {m_lvl, m_pulse, m_valid, m_code}) begin
                n_bad++; $display("FAIL glitch_model t=%0d: got %h want %h", t, {bus.key_level, bus.key_pulse, bus.evt_valid, bus.evt_code}, {m_lvl, m_pulse, m_valid, m_code});
            end
            if (bus.key_pulse != 4'd0 || bus.evt_valid || bus.key_level[1]) act++;
        end
        n_vec++;
        if (act != 0) begin
            n_bad++; $display("FAIL glitch_quiet: got %0d active cycles want 0", act);
        end
    endtask

    task automatic check_pulse_list(input string name, input int got[$], input int want[$]);
        // Compares a recorded pulse timeline with its expected one.
        n_vec++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d pulses (first %0d) want %0d pulses (first %0d)", name, got.size(),
                     (got.size() > 0) ? got[0] : -1, want.size(), (want.size() > 0) ? want[0] : -1);
        end
    endtask

    task automatic test_auto_repeat();
        int got[$];
        int want[$];
        int e;
        // Release is driven before edge 31 and seen by the FSM at edge 33.
        e = DB + 3; want.push_back(e); e += HOLD;
        while (e <= 32) begin want.push_back(e); e += RPT; end
        bus.rpt_en = 1'b1;
        bus.key_in = 4'b0001;
        for (int t = 1; t <= 45; t++) begin
            if (t == 31) bus.key_in = 4'b0000;
            tick();
            n_vec++;
            if ({bus.key_level, bus.key_pulse, bus.evt_valid, bus.evt_code} !== {m_lvl, m_pulse, m_valid, m_code}) begin
                n_bad++; $display("FAIL repeat_model t=%0d: got %h want %h", t, {bus.key_level, bus.key_pulse, bus.evt_valid, bus.evt_code}, {m_lvl, m_pulse, m_valid, m_code});
            end
            if (bus.key_pulse[0]) got.push_back(t);
        end
        bus.rpt_en = 1'b0;
        n_vec++;
        if (got != want) begin
            n_bad++; $display("FAIL repeat_times: got %0d pulses want %0d (7,17,20,23,26,29,32)", got.size(), want.size());
        end
    endtask

    task automatic test_simultaneous();
        int p0 = -1, p2 = -1, nevt = 0;
        logic [1:0] c8 = 2'd3, c9 = 2'd3;
        bus.key_in = 4'b0101;
        for (int t = 1; t <= 35; t++) begin
            if (t == 21) bus.key_in = 4'b0000;
            tick();
            n_vec++;
            if ({bus.key_level, bus.key_pulse, bus.evt_valid, bus.evt_code} !== {m_lvl, m_pulse, m_valid, m_code}) begin
                n_bad++; $display("FAIL simul_model t=%0d: got %h want %h", t, {bus.key_level, bus.key_pulse, bus.evt_valid, bus.evt_code}, {m_lvl, m_pulse, m_valid, m_code});
            end
            if (bus.key_pulse[0]) p0 = t;
            if (bus.key_pulse[2]) p2 = t;
            if (bus.evt_valid) begin
                nevt++;
                if (t == DB + 4) c8 = bus.evt_code;
                if (t == DB + 5) c9 = bus.evt_code;
            end
        end
        n_vec++;
        if (p0 != DB + 3 || p2 != DB + 3) begin
            n_bad++; $display("FAIL simul_pulse: got key0 %0d key2 %0d want both %0d", p0, p2, DB + 3);
        end
        n_vec++;
        if (nevt != 2 || c8 !== 2'd0 || c9 !== 2'd2) begin
            n_bad++; $display("FAIL simul_events: got %0d events codes %0d,%0d want 2 events codes 0,2", nevt, c8, c9);
        end
    endtask

    task automatic test_release_bounce();
        int got[$];
        int want[$];
        int low_lvl = 0;
        // Key drops before edges 10,11; FSM sees it back at edge 14.
        want.push_back(DB + 3);
        for (int e = 14 + HOLD; e <= 32; e += RPT) want.push_back(e);
        bus.rpt_en = 1'b1;
        bus.key_in = 4'b0001;
        for (int t = 1; t <= 45; t++) begin
            if (t == 10) bus.key_in = 4'b0000;
            if (t == 12) bus.key_in = 4'b0001;
            if (t == 31) bus.key_in = 4'b0000;
            tick();
            n_vec++;
            if ({bus.key_level, bus.key_pulse, bus.evt_valid, bus.evt_code} !== {m_lvl, m_pulse, m_valid, m_code}) begin
                n_bad++; $display("FAIL bounce_model t=%0d: got %h want %h", t, {bus.key_level, bus.key_pulse, bus.evt_valid, bus.evt_code}, {m_lvl, m_pulse, m_valid, m_code});
            end
            if (bus.key_pulse[0]) got.push_back(t);
            if (t >= DB + 3 && t <= 32 && !bus.key_level[0]) low_lvl++;
        end
        bus.rpt_en = 1'b0;
        check_pulse_list("bounce_times", got, want);
        n_vec++;
        if (low_lvl != 0) begin
            n_bad++; $display("FAIL bounce_level: got %0d low cycles while held want 0", low_lvl);
        end
    endtask

    task automatic test_reset_mid();
        int p_at = -1;
        bus.key_in = 4'b1000;
        repeat (4) tick();
        rstn = 1'b0;
        tick();
        n_vec++;
        if ({bus.key_level, bus.key_pulse, bus.evt_valid, bus.evt_code} !== 11'd0) begin
            n_bad++; $display("FAIL rstmid_outputs: got %h want 000", {bus.key_level, bus.key_pulse, bus.evt_valid, bus.evt_code});
        end
        rstn = 1'b1;
        for (int t = 1; t <= 12; t++) begin
            tick();
            n_vec++;
            if ({bus.key_level, bus.key_pulse, bus.evt_valid, bus.evt_code} !== {m_lvl, m_pulse, m_valid, m_code}) begin
                n_bad++; $display("FAIL rstmid_model t=%0d: got %h want %h", t, {bus.key_level, bus.key_pulse, bus.evt_valid, bus.evt_code}, {m_lvl, m_pulse, m_valid, m_code});
            end
            if (bus.key_pulse[3] && p_at < 0) p_at = t;
        end
        n_vec++;
        if (p_at != DB + 3) begin
            n_bad++; $display("FAIL rstmid_pulse: got %0d want %0d", p_at, DB + 3);
        end
        bus.key_in = 4'b0000;
        repeat (12) tick();
    endtask

    task automatic test_back_to_back();
        int npulse = 0, nevt = 0;
        bus.rpt_en = 1'b1;
        bus.key_in = 4'b1111;
        for (int t = 1; t <= 60; t++) begin
            if (t == 41) bus.key_in = 4'b0000;
            tick();
            n_vec++;
            if ({bus.key_level, bus.key_pulse, bus.evt_valid, bus.evt_code} !== {m_lvl, m_pulse, m_valid, m_code}) begin
                n_bad++; $display("FAIL b2b_model t=%0d: got %h want %h", t, {bus.key_level, bus.key_pulse, bus.evt_valid, bus.evt_code}, {m_lvl, m_pulse, m_valid, m_code});
            end
            npulse += $countones(bus.key_pulse);
            if (bus.evt_valid) nevt++;
        end
        bus.rpt_en = 1'b0;
        // Four keys repeating every 3 cycles outrun one event per cycle, so pulses must merge.
        n_vec++;
        if (!(nevt < npulse) || nevt == 0) begin
            n_bad++; $display("FAIL b2b_merge: got %0d events for %0d pulses want fewer events", nevt, npulse);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] k;
        k = '0;
        for (int t = 0; t < 2000; t++) begin
            for (int i = 0; i < N; i++) if ($urandom_range(0, 9) == 0) k[i] = ~k[i];
            bus.key_in = k;
            if ($urandom_range(0, 39) == 0) bus.rpt_en = ~bus.rpt_en;
            rstn = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
            tick();
            n_vec++;
            if ({bus.key_level, bus.key_pulse, bus.evt_valid, bus.evt_code} !== {m_lvl, m_pulse, m_valid, m_code}) begin
                n_bad++; $display("FAIL random_model t=%0d: got %h want %h", t, {bus.key_level, bus.key_pulse, bus.evt_valid, bus.evt_code}, {m_lvl, m_pulse, m_valid, m_code});
            end
        end
        rstn = 1'b1;
        bus.key_in = '0;
        repeat (15) tick();
    endtask

    initial begin
        rstn = 1'b1;
        bus.key_in = '0;  bus.rpt_en = 1'b0;
        bus1.key_in = '0; bus1.rpt_en = 1'b0;
        model_reset();
        #2 rstn = 1'b0;
        test_reset();
        test_db1();
        test_clean_press();
        test_glitch();
        test_auto_repeat();
        test_simultaneous();
        test_release_bounce();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
